// File: rtl/pcie_ss_csr_arb.sv
// Shares the indirect CSR command port between host CSR accesses and buffered
// hardware error reports, each report written out as one atomic multi-write sequence.
module pcie_ss_csr_arb #(
    parameter int                    ADDR_WIDTH     = 20,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    HDR_WIDTH      = 256,
    parameter int                    PF_WIDTH       = 3,
    parameter int                    VF_WIDTH       = 11,
    parameter int                    ERR_FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] ERR_HDR_BASE   = 20'h0_0100,
    parameter logic [ADDR_WIDTH-1:0] ERR_CODE_ADDR  = 20'h0_0120,
    parameter logic [ADDR_WIDTH-1:0] ERR_CTL_ADDR   = 20'h0_0124
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_host_cmd,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_writedata,
    output logic                  o_host_ack,
    output logic [DATA_WIDTH-1:0] o_host_readdata,
    output logic [1:0]            o_host_resp,
    input  logic                  i_err_valid,
    input  logic [HDR_WIDTH-1:0]  i_err_hdr,
    input  logic [PF_WIDTH-1:0]   i_err_pf,
    input  logic [VF_WIDTH-1:0]   i_err_vf,
    input  logic                  i_err_vf_active,
    input  logic [31:0]           i_err_code,
    output logic [1:0]            o_csr_cmd,
    output logic [ADDR_WIDTH-1:0] o_csr_addr,
    output logic [DATA_WIDTH-1:0] o_csr_writedata,
    input  logic                  i_csr_ack,
    input  logic [DATA_WIDTH-1:0] i_csr_readdata,
    input  logic [1:0]            i_csr_rresp,
    input  logic [1:0]            i_csr_bresp,
    output logic                  o_err_overflow,
    output logic [15:0]           o_err_drop_cnt,
    output logic                  o_err_wr_fail
);
    localparam int HDR_WORDS = HDR_WIDTH / DATA_WIDTH;
    localparam int IDX_W     = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam int PTR_W     = $clog2(ERR_FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int REC_W     = HDR_WIDTH + PF_WIDTH + VF_WIDTH + 1 + 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOST     = 3'd1,
        ST_ERR_HDR  = 3'd2,
        ST_ERR_CODE = 3'd3,
        ST_ERR_CTL  = 3'd4
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] hdr_word(input logic [HDR_WIDTH-1:0] hdr,
                                                       input logic [IDX_W-1:0] idx);
        return DATA_WIDTH'(hdr >> (DATA_WIDTH * int'(idx)));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] hdr_addr(input logic [IDX_W-1:0] idx);
        return ERR_HDR_BASE + ADDR_WIDTH'(4 * int'(idx));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ctl_word(input logic [PF_WIDTH-1:0] pf,
                                                       input logic [VF_WIDTH-1:0] vf,
                                                       input logic vf_active);
        logic [DATA_WIDTH-1:0] w;
        w                                      = '0;
        w[0]                                   = 1'b1;
        w[1]                                   = vf_active;
        w[PF_WIDTH+1:2]                        = pf;
        w[PF_WIDTH+VF_WIDTH+1:PF_WIDTH+2]      = vf;
        return w;
    endfunction

    state_t                state_r, state_next_s;
    logic [IDX_W-1:0]      idx_r, idx_next_s;
    logic                  last_err_r, last_err_next_s;
    logic [1:0]            csr_cmd_r, csr_cmd_next_s;
    logic [ADDR_WIDTH-1:0] csr_addr_r, csr_addr_next_s;
    logic [DATA_WIDTH-1:0] csr_wdata_r, csr_wdata_next_s;
    logic                  host_ack_r, host_ack_next_s;
    logic [DATA_WIDTH-1:0] host_rdata_r, host_rdata_next_s;
    logic [1:0]            host_resp_r, host_resp_next_s;
    logic                  err_overflow_r, wr_fail_r;
    logic [15:0]           drop_cnt_r;

    logic [REC_W-1:0]      fifo_mem_r [ERR_FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]      fifo_cnt_r;
    logic                  fifo_full_s, push_s, drop_s, pop_s, wr_fail_set_s;
    logic                  host_pend_s, err_pend_s, grant_err_s, grant_host_s;
    logic [REC_W-1:0]      rec_in_s, head_s;
    logic [HDR_WIDTH-1:0]  head_hdr_s;
    logic [PF_WIDTH-1:0]   head_pf_s;
    logic [VF_WIDTH-1:0]   head_vf_s;
    logic                  head_vfa_s;
    logic [31:0]           head_code_s;

    assign rec_in_s    = {i_err_hdr, i_err_pf, i_err_vf, i_err_vf_active, i_err_code};
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign head_hdr_s  = head_s[REC_W-1 -: HDR_WIDTH];
    assign head_pf_s   = head_s[33+VF_WIDTH +: PF_WIDTH];
    assign head_vf_s   = head_s[33 +: VF_WIDTH];
    assign head_vfa_s  = head_s[32];
    assign head_code_s = head_s[31:0];

    // A push into a full FIFO still lands when the head is popped that same cycle.
    assign fifo_full_s = (fifo_cnt_r == CNT_W'(ERR_FIFO_DEPTH));
    assign push_s      = i_err_valid && (!fifo_full_s || pop_s);
    assign drop_s      = i_err_valid && !push_s;

    // A host request still held during its own ack cycle must not be granted again.
    assign host_pend_s  = ((i_host_cmd == 2'b01) || (i_host_cmd == 2'b10)) && !host_ack_r;
    assign err_pend_s   = (fifo_cnt_r != CNT_W'(0));
    assign grant_err_s  = err_pend_s && (!host_pend_s || !last_err_r);
    assign grant_host_s = host_pend_s && (!err_pend_s || last_err_r);

    // Next-state, next-command and host completion decode.
    always_comb begin
        state_next_s      = state_r;
        idx_next_s        = idx_r;
        last_err_next_s   = last_err_r;
        csr_cmd_next_s    = csr_cmd_r;
        csr_addr_next_s   = csr_addr_r;
        csr_wdata_next_s  = csr_wdata_r;
        host_ack_next_s   = 1'b0;
        host_rdata_next_s = host_rdata_r;
        host_resp_next_s  = host_resp_r;
        pop_s             = 1'b0;
        wr_fail_set_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_err_s) begin
                    state_next_s     = ST_ERR_HDR;
                    idx_next_s       = IDX_W'(0);
                    csr_cmd_next_s   = 2'b01;
                    csr_addr_next_s  = hdr_addr(IDX_W'(0));
                    csr_wdata_next_s = hdr_word(head_hdr_s, IDX_W'(0));
                end else if (grant_host_s) begin
                    state_next_s     = ST_HOST;
                    csr_cmd_next_s   = i_host_cmd;
                    csr_addr_next_s  = i_host_addr;
                    csr_wdata_next_s = i_host_writedata;
                end else begin
                    csr_cmd_next_s   = 2'b00;
                end
            end
            ST_HOST: begin
                if (i_csr_ack) begin
                    state_next_s      = ST_IDLE;
                    csr_cmd_next_s    = 2'b00;
                    host_ack_next_s   = 1'b1;
                    host_rdata_next_s = i_csr_readdata;
                    host_resp_next_s  = (csr_cmd_r == 2'b10) ? i_csr_rresp : i_csr_bresp;
                    last_err_next_s   = 1'b0;
                end else begin
                    state_next_s      = ST_HOST;
                end
            end
            ST_ERR_HDR: begin
                if (i_csr_ack) begin
                    wr_fail_set_s = (i_csr_bresp != 2'b00);
                    if (idx_r == IDX_W'(HDR_WORDS - 1)) begin
                        state_next_s     = ST_ERR_CODE;
                        csr_addr_next_s  = ERR_CODE_ADDR;
                        csr_wdata_next_s = DATA_WIDTH'(head_code_s);
                    end else begin
                        idx_next_s       = idx_r + IDX_W'(1);
                        csr_addr_next_s  = hdr_addr(idx_r + IDX_W'(1));
                        csr_wdata_next_s = hdr_word(head_hdr_s, idx_r + IDX_W'(1));
                    end
                end else begin
                    state_next_s = ST_ERR_HDR;
                end
            end
            ST_ERR_CODE: begin
                if (i_csr_ack) begin
                    wr_fail_set_s    = (i_csr_bresp != 2'b00);
                    state_next_s     = ST_ERR_CTL;
                    csr_addr_next_s  = ERR_CTL_ADDR;
                    csr_wdata_next_s = ctl_word(head_pf_s, head_vf_s, head_vfa_s);
                end else begin
                    state_next_s = ST_ERR_CODE;
                end
            end
            ST_ERR_CTL: begin
                if (i_csr_ack) begin
                    wr_fail_set_s   = (i_csr_bresp != 2'b00);
                    state_next_s    = ST_IDLE;
                    csr_cmd_next_s  = 2'b00;
                    last_err_next_s = 1'b1;
                    pop_s           = 1'b1;
                end else begin
                    state_next_s = ST_ERR_CTL;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                csr_cmd_next_s = 2'b00;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_W'(0);
            last_err_r   <= 1'b0;
            csr_cmd_r    <= 2'b00;
            csr_addr_r   <= '0;
            csr_wdata_r  <= '0;
            host_ack_r   <= 1'b0;
            host_rdata_r <= '0;
            host_resp_r  <= 2'b00;
        end else begin
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            last_err_r   <= last_err_next_s;
            csr_cmd_r    <= csr_cmd_next_s;
            csr_addr_r   <= csr_addr_next_s;
            csr_wdata_r  <= csr_wdata_next_s;
            host_ack_r   <= host_ack_next_s;
            host_rdata_r <= host_rdata_next_s;
            host_resp_r  <= host_resp_next_s;
        end
    end

    // FIFO pointers, occupancy and sticky error status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= PTR_W'(0);
            rd_ptr_r       <= PTR_W'(0);
            fifo_cnt_r     <= CNT_W'(0);
            err_overflow_r <= 1'b0;
            drop_cnt_r     <= 16'h0000;
            wr_fail_r      <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            fifo_cnt_r <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
            if (drop_s) err_overflow_r <= 1'b1;
            if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'h0001;
            if (wr_fail_set_s) wr_fail_r <= 1'b1;
        end
    end

    // Record storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= rec_in_s;
    end

    assign o_csr_cmd       = csr_cmd_r;
    assign o_csr_addr      = csr_addr_r;
    assign o_csr_writedata = csr_wdata_r;
    assign o_host_ack      = host_ack_r;
    assign o_host_readdata = host_rdata_r;
    assign o_host_resp     = host_resp_r;
    assign o_err_overflow  = err_overflow_r;
    assign o_err_drop_cnt  = drop_cnt_r;
    assign o_err_wr_fail   = wr_fail_r;
endmodule

// File: tb/tb_pcie_ss_csr_arb.sv
// Directed bench for pcie_ss_csr_arb: a 3-cycle-latency engine model logs every
// completed command, and directed scenarios compare against hand-computed values.
module tb_pcie_ss_csr_arb;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   i_host_cmd;
    logic [19:0]  i_host_addr;
    logic [31:0]  i_host_writedata;
    logic         o_host_ack;
    logic [31:0]  o_host_readdata;
    logic [1:0]   o_host_resp;
    logic         i_err_valid;
    logic [255:0] i_err_hdr;
    logic [2:0]   i_err_pf;
    logic [10:0]  i_err_vf;
    logic         i_err_vf_active;
    logic [31:0]  i_err_code;
    logic [1:0]   o_csr_cmd;
    logic [19:0]  o_csr_addr;
    logic [31:0]  o_csr_writedata;
    logic         i_csr_ack;
    logic [31:0]  i_csr_readdata;
    logic [1:0]   i_csr_rresp;
    logic [1:0]   i_csr_bresp;
    logic         o_err_overflow;
    logic [15:0]  o_err_drop_cnt;
    logic         o_err_wr_fail;

    pcie_ss_csr_arb dut (
        .clk(clk), .rst_n(rst_n),
        .i_host_cmd(i_host_cmd), .i_host_addr(i_host_addr), .i_host_writedata(i_host_writedata),
        .o_host_ack(o_host_ack), .o_host_readdata(o_host_readdata), .o_host_resp(o_host_resp),
        .i_err_valid(i_err_valid), .i_err_hdr(i_err_hdr), .i_err_pf(i_err_pf), .i_err_vf(i_err_vf),
        .i_err_vf_active(i_err_vf_active), .i_err_code(i_err_code),
        .o_csr_cmd(o_csr_cmd), .o_csr_addr(o_csr_addr), .o_csr_writedata(o_csr_writedata),
        .i_csr_ack(i_csr_ack), .i_csr_readdata(i_csr_readdata),
        .i_csr_rresp(i_csr_rresp), .i_csr_bresp(i_csr_bresp),
        .o_err_overflow(o_err_overflow), .o_err_drop_cnt(o_err_drop_cnt), .o_err_wr_fail(o_err_wr_fail)
    );

    always #5 clk = ~clk;

    int          chk_total = 0;
    int          chk_pass  = 0;
    bit          eng_en = 1'b1;
    bit          eng_bad_code = 1'b0;
    logic [31:0] eng_rdata = 32'h0;
    logic [1:0]  eng_rresp = 2'b00;
    int          eng_busy = 0;
    logic [19:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [1:0]  log_cmd  [$];
    longint      log_time [$];

    logic [31:0] h_rd;
    logic [1:0]  h_resp;
    int          h_cyc;
    bit          h_got;
    logic [1:0]  h_cmd_at_ack;
    int          base;
    longint      t0;
    bit          found;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Engine model: acks the LAT-th cycle a command is visible, logs the completed command.
    initial begin
        i_csr_ack = 1'b0; i_csr_readdata = 32'h0; i_csr_rresp = 2'b00; i_csr_bresp = 2'b00;
        forever begin
            @(negedge clk);
            i_csr_ack = 1'b0; i_csr_rresp = 2'b00; i_csr_bresp = 2'b00;
            if (o_csr_cmd == 2'b00) begin
                eng_busy = 0;
            end else if (eng_en) begin
                eng_busy++;
                if (eng_busy >= LAT) begin
                    eng_busy       = 0;
                    i_csr_ack      = 1'b1;
                    i_csr_readdata = eng_rdata;
                    i_csr_rresp    = eng_rresp;
                    i_csr_bresp    = (eng_bad_code && o_csr_addr == 20'h00120) ? 2'b10 : 2'b00;
                    log_addr.push_back(o_csr_addr);
                    log_data.push_back(o_csr_writedata);
                    log_cmd.push_back(o_csr_cmd);
                    log_time.push_back($time);
                end
            end
        end
    end

    task automatic push_err(input logic [31:0] code, input logic [2:0] pf,
                            input logic [10:0] vf, input logic vfa);
        for (int k = 0; k < 8; k++) i_err_hdr[32*k +: 32] = 32'(k);
        i_err_pf = pf; i_err_vf = vf; i_err_vf_active = vfa; i_err_code = code;
        i_err_valid = 1'b1;
        @(negedge clk);
        i_err_valid = 1'b0;
    endtask

    task automatic host_access(input logic [1:0] cmd, input logic [19:0] addr, input logic [31:0] wd,
                               output logic [31:0] rd, output logic [1:0] resp, output int cyc,
                               output bit got, output logic [1:0] cmd_at_ack);
        i_host_cmd = cmd; i_host_addr = addr; i_host_writedata = wd;
        cyc = 0; got = 1'b0; rd = 32'h0; resp = 2'b00; cmd_at_ack = 2'b00;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (o_host_ack) begin
                got = 1'b1; rd = o_host_readdata; resp = o_host_resp; cmd_at_ack = o_csr_cmd;
            end else if (o_csr_cmd == cmd && o_csr_addr == addr) begin
                cyc++;
            end
        end
        i_host_cmd = 2'b00;
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget && log_addr.size() < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        i_host_cmd = 2'b00; i_host_addr = 20'h0; i_host_writedata = 32'h0;
        i_err_valid = 1'b0; i_err_hdr = '0; i_err_pf = 3'd0; i_err_vf = 11'd0;
        i_err_vf_active = 1'b0; i_err_code = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_csr_cmd", o_csr_cmd, 2'b00);
        check_eq("rst_host_ack", o_host_ack, 1'b0);
        check_eq("rst_overflow", o_err_overflow, 1'b0);
        check_eq("rst_drop_cnt", o_err_drop_cnt, 16'h0);
        check_eq("rst_wr_fail", o_err_wr_fail, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Host write then reads (rresp path selected on read).
        base = log_addr.size();
        host_access(2'b01, 20'h00010, 32'hDEADBEEF, h_rd, h_resp, h_cyc, h_got, h_cmd_at_ack);
        check_eq("hw_ack", h_got, 1'b1);
        check_eq("hw_cmd_cycles", h_cyc, LAT);
        check_eq("hw_cmd_idle_at_ack", h_cmd_at_ack, 2'b00);
        check_eq("hw_resp", h_resp, 2'b00);
        check_eq("hw_log_data", log_data[base], 32'hDEADBEEF);
        @(negedge clk);
        check_eq("hw_ack_pulse", o_host_ack, 1'b0);
        eng_rdata = 32'h12345678;
        host_access(2'b10, 20'h00014, 32'h0, h_rd, h_resp, h_cyc, h_got, h_cmd_at_ack);
        check_eq("hr_ack", h_got, 1'b1);
        check_eq("hr_rdata", h_rd, 32'h12345678);
        check_eq("hr_resp", h_resp, 2'b00);
        eng_rdata = 32'h0BADF00D; eng_rresp = 2'b10;
        host_access(2'b10, 20'h00018, 32'h0, h_rd, h_resp, h_cyc, h_got, h_cmd_at_ack);
        check_eq("hr2_rdata", h_rd, 32'h0BADF00D);
        check_eq("hr2_rresp", h_resp, 2'b10);
        eng_rresp = 2'b00;

        // Single error record: 8 header words, code, control.
        base = log_addr.size();
        t0 = $time;
        push_err(32'h40, 3'd2, 11'd5, 1'b1);
        wait_log(base + 10, 200);
        check_eq("se_count", log_addr.size(), base + 10);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("se_hdr%0d_addr", k), log_addr[base+k], 20'h00100 + 20'(4*k));
            check_eq($sformatf("se_hdr%0d_data", k), log_data[base+k], 32'(k));
        end
        check_eq("se_code_addr", log_addr[base+8], 20'h00120);
        check_eq("se_code_data", log_data[base+8], 32'h40);
        check_eq("se_ctl_addr", log_addr[base+9], 20'h00124);
        check_eq("se_ctl_data", log_data[base+9], 32'h000000AB);
        check_eq("se_first_ack_time", log_time[base] - t0, 64'd40);
        check_eq("se_last_ack_time", log_time[base+9] - t0, 64'd310);
        repeat (20) @(negedge clk);
        check_eq("se_fifo_empty", log_addr.size(), base + 10);

        // Simultaneous after reset: error first, then host, then a queued error.
        do_reset();
        base = log_addr.size();
        push_err(32'h11, 3'd2, 11'd5, 1'b1);
        fork
            host_access(2'b01, 20'h00200, 32'hCAFE0001, h_rd, h_resp, h_cyc, h_got, h_cmd_at_ack);
            begin
                repeat (3) @(negedge clk);
                push_err(32'h22, 3'd2, 11'd5, 1'b1);
            end
        join
        wait_log(base + 21, 300);
        check_eq("tie_count", log_addr.size(), base + 21);
        check_eq("tie_host_ack", h_got, 1'b1);
        check_eq("tie_err_first", log_addr[base], 20'h00100);
        check_eq("tie_err1_code", log_data[base+8], 32'h11);
        check_eq("tie_host_second", log_addr[base+10], 20'h00200);
        check_eq("tie_host_data", log_data[base+10], 32'hCAFE0001);
        check_eq("tie_err2_code", log_data[base+19], 32'h22);

        // Host request arriving during header word 3 waits for the control write.
        base = log_addr.size();
        push_err(32'h33, 3'd2, 11'd5, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (o_csr_cmd == 2'b01 && o_csr_addr == 20'h0010C) found = 1'b1;
        end
        check_eq("mid_hdr3_seen", found, 1'b1);
        eng_rdata = 32'hA5A5A5A5;
        host_access(2'b10, 20'h00300, 32'h0, h_rd, h_resp, h_cyc, h_got, h_cmd_at_ack);
        wait_log(base + 11, 100);
        check_eq("mid_host_ack", h_got, 1'b1);
        check_eq("mid_host_rdata", h_rd, 32'hA5A5A5A5);
        check_eq("mid_ctl_before_host", log_addr[base+9], 20'h00124);
        check_eq("mid_host_after", log_addr[base+10], 20'h00300);
        check_eq("mid_host_cmd", log_cmd[base+10], 2'b10);

        // Overflow with the engine stalled.
        eng_en = 1'b0;
        base = log_addr.size();
        i_err_valid = 1'b1;
        for (int r = 0; r < 6; r++) begin
            i_err_code = 32'h51 + 32'(r);
            @(negedge clk);
        end
        i_err_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("ovf_drop_cnt", o_err_drop_cnt, 16'd2);
        check_eq("ovf_sticky", o_err_overflow, 1'b1);
        check_eq("ovf_cmd_held", o_csr_cmd, 2'b01);
        eng_en = 1'b1;
        wait_log(base + 40, 600);
        check_eq("ovf_count", log_addr.size(), base + 40);
        for (int r = 0; r < 4; r++) begin
            check_eq($sformatf("ovf_seq%0d_code", r), log_data[base+10*r+8], 32'h51 + 32'(r));
            check_eq($sformatf("ovf_seq%0d_ctl", r), log_addr[base+10*r+9], 20'h00124);
        end
        repeat (20) @(negedge clk);
        check_eq("ovf_no_extra", log_addr.size(), base + 40);

        // Reset during header word 2 aborts and flushes.
        push_err(32'h77, 3'd2, 11'd5, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (o_csr_cmd == 2'b01 && o_csr_addr == 20'h00108) found = 1'b1;
        end
        check_eq("rst2_hdr2_seen", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst2_csr_cmd", o_csr_cmd, 2'b00);
        check_eq("rst2_csr_addr", o_csr_addr, 20'h0);
        check_eq("rst2_csr_wdata", o_csr_writedata, 32'h0);
        check_eq("rst2_rdata", o_host_readdata, 32'h0);
        check_eq("rst2_overflow", o_err_overflow, 1'b0);
        check_eq("rst2_drop_cnt", o_err_drop_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        base = log_addr.size();
        repeat (40) @(negedge clk);
        check_eq("rst2_no_writes", log_addr.size(), base);
        check_eq("rst2_csr_idle", o_csr_cmd, 2'b00);

        // Write failure on the error-code write; control write still issued.
        check_eq("wf_clear_before", o_err_wr_fail, 1'b0);
        eng_bad_code = 1'b1;
        base = log_addr.size();
        push_err(32'h88, 3'd7, 11'h7FF, 1'b0);
        wait_log(base + 10, 200);
        check_eq("wf_count", log_addr.size(), base + 10);
        check_eq("wf_sticky", o_err_wr_fail, 1'b1);
        check_eq("wf_ctl_addr", log_addr[base+9], 20'h00124);
        check_eq("wf_ctl_data", log_data[base+9], 32'h0000FFFD);
        eng_bad_code = 1'b0;

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end
endmodule

// File: doc/pcie_ss_csr_arb.md
# pcie_ss_csr_arb

Sequencer and arbiter in front of the PCIe SS AXI-lite indirect CSR engine. It shares the single CSR command port between two requesters: host indirect CSR requests from the PCIe CSR block, and hardware error reports. Incoming error reports are buffered in a FIFO. Each report is then written into the PCIe SS error header, error code and ERROR_GEN_CTL registers as one atomic multi-write sequence.

## Interface
- ADDR_WIDTH, 20, CSR address width.
- DATA_WIDTH, 32, CSR data width.
- HDR_WIDTH, 256, error header width; must be a multiple of DATA_WIDTH. HDR_WORDS = HDR_WIDTH/DATA_WIDTH.
- PF_WIDTH, 3, PF number width.
- VF_WIDTH, 11, VF number width. PF_WIDTH+VF_WIDTH+2 must be ≤ DATA_WIDTH.
- ERR_FIFO_DEPTH, 4, number of error records buffered; power of 2, ≥ 2.
- ERR_HDR_BASE, 20'h0_0100, address of header word 0.
- ERR_CODE_ADDR, 20'h0_0120, error code register address.
- ERR_CTL_ADDR, 20'h0_0124, ERROR_GEN_CTL register address.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_host_cmd  in  2  host request: 2'b01 write, 2'b10 read, 00/11 idle. Held until o_host_ack.
- i_host_addr  in  ADDR_WIDTH  host address.
- i_host_writedata  in  DATA_WIDTH  host write data.
- o_host_ack  out  1  one-cycle completion pulse to the host.
- o_host_readdata  out  DATA_WIDTH  read data; valid with o_host_ack.
- o_host_resp  out  2  rresp or bresp of the completed host access; valid with o_host_ack.
- i_err_valid  in  1  one-cycle error record strobe.
- i_err_hdr  in  HDR_WIDTH  error TLP header.
- i_err_pf  in  PF_WIDTH  PF of the error.
- i_err_vf  in  VF_WIDTH  VF of the error.
- i_err_vf_active  in  1  VF active flag.
- i_err_code  in  32  error code.
- o_csr_cmd  out  2  command to the indirect engine; same encoding as i_host_cmd.
- o_csr_addr  out  ADDR_WIDTH  engine address.
- o_csr_writedata  out  DATA_WIDTH  engine write data.
- i_csr_ack  in  1  engine completion pulse.
- i_csr_readdata  in  DATA_WIDTH  engine read data.
- i_csr_rresp  in  2  engine read response.
- i_csr_bresp  in  2  engine write response.
- o_err_overflow  out  1  sticky: an error record was dropped because the FIFO was full.
- o_err_drop_cnt  out  16  count of dropped error records; saturates at 16'hFFFF.
- o_err_wr_fail  out  1  sticky: an error-sequence write returned bresp != 2'b00.

## Operation
- **Reset values.** All outputs are 0. FIFO is empty. FSM is in IDLE. The last-grant pointer is HOST, so error reports win the first tie.
- **FIFO push.** Each record is {hdr, pf, vf, vf_active, code}. i_err_valid pushes a record when the FIFO is not full. When full, the record is dropped, the counter increments and o_err_overflow sets.
- **FIFO pop.** The head record stays in place for the whole sequence. It is popped on the ack of the ERROR_GEN_CTL write. A push while full in the same cycle as that pop is accepted.
- **FSM states.** IDLE, HOST, ERR_HDR (word index 0..HDR_WORDS-1), ERR_CODE, ERR_CTL.
- **IDLE arbitration.**
  - Host pending: i_host_cmd is 01 or 10, and o_host_ack is not high this cycle.
  - Error pending: FIFO not empty.
  - If only one is pending, grant it. If both are pending, grant the requester that was not granted last.
- **HOST state.**
  - o_csr_cmd, o_csr_addr and o_csr_writedata carry the registered host request.
  - On i_csr_ack: latch i_csr_readdata. Latch i_csr_rresp for a read or i_csr_bresp for a write. Pulse o_host_ack. Set last=HOST. Return to IDLE.
- **ERR_HDR word i.**
  - Write cmd, addr = ERR_HDR_BASE + 4*i, data = hdr[DATA_WIDTH*i +: DATA_WIDTH].
  - On ack: if i < HDR_WORDS-1, go to word i+1; otherwise go to ERR_CODE.
- **ERR_CODE.** Write code to ERR_CODE_ADDR.
- **ERR_CTL.**
  - Write to ERR_CTL_ADDR with data: [0]=1 (trigger), [1]=vf_active, [PF_WIDTH+1:2]=pf, [PF_WIDTH+VF_WIDTH+1:PF_WIDTH+2]=vf, all other bits 0.
  - On ack: pop the FIFO, set last=ERR, return to IDLE.
- **Atomicity.** An error sequence is never interleaved with host accesses. A host request arriving mid-sequence waits.
- **Error-write responses.** Any error-sequence ack with bresp != 0 sets o_err_wr_fail. The sequence continues regardless.
- **Ignored inputs.** i_host_cmd of 2'b11 is treated as idle. i_csr_ack in IDLE is ignored.

## Timing
- A request visible in IDLE at cycle N drives o_csr_cmd from cycle N+1. All outputs are registered.
- o_csr_cmd and its address/data stay stable until i_csr_ack.
- **Ack at cycle M within an error sequence.** The next write is driven at M+1 with no idle gap.
- **Ack at cycle M ending a transaction.** o_csr_cmd is 0 at M+1. o_host_ack pulses at M+1 for host transactions. The next grant drives o_csr_cmd at M+2 at the earliest.
- **Host obligations.** The host drops i_host_cmd within one cycle after o_host_ack. A request still present during the o_host_ack cycle is not re-granted.
- **Error sequence latency.** HDR_WORDS+2 writes. With the engine acking L cycles after command, the sequence takes (HDR_WORDS+2)*L cycles plus 1 grant cycle.
- **Reset.** rst_n asserted mid-transaction aborts immediately: FIFO flushed, counters and stickies cleared, o_csr_cmd = 0 asynchronously.

## Test plan
- **Host write, then read.** Host write 0x00010 / 0xDEADBEEF with the engine acking 3 cycles after command. Expect o_csr_cmd=01 for 3 cycles, o_host_ack one cycle later, o_host_resp=0. Then a host read with readdata 0x12345678 returns o_host_readdata=0x12345678.
- **Single error record.** Push one record: hdr word k = k, pf=2, vf=5, vf_active=1, code=0x40. Expect 10 writes at 0x100..0x11C carrying data 0..7, then 0x120 with 0x40, then 0x124 with 0x000000AB. FIFO empty afterwards.
- **Simultaneous host and error in IDLE after reset.** Expect the error sequence first, then the host access. A second simultaneous pair after that alternates to the host first.
- **Host request mid-sequence.** Assert a host request during header word 3. Expect no host command until after the ERR_CTL ack, then the host is granted.
- **Overflow.** Push 6 records back-to-back with the engine stalled (no acks). Expect 4 accepted, o_err_drop_cnt=2, o_err_overflow=1. Release the engine and expect 4 complete sequences.
- **Reset and write failure.** Assert rst_n low during ERR_HDR word 2: expect all outputs 0 and no further writes after release. Separately, return bresp=2'b10 on ERR_CODE: expect o_err_wr_fail=1 and ERR_CTL still issued.
